// File: rtl/control_booth.sv
// -----------------------------------------------------------------------------
// control_booth
//
// Control unit (FSM plus iteration counter) for a radix-2 Booth multiplier
// datapath made of A (accumulator), Q (multiplier), M (sign-extended
// multiplicand), the Q-1 flip-flop and an add/subtract unit.
//
// After a start request the unit loads the operands and then runs N
// iterations. Each iteration inspects {Q[0], Q-1}, optionally adds or
// subtracts M into A, and then arithmetic-shifts A:Q:Q-1 right by one.
// Completion is signalled with a level handshake: fin stays high until
// comienzo is released.
//
// Parameters
//   N   number of Booth iterations (width of Q), 1..15
//   CW  width of the iteration counter, 2**CW > N
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   comienzo   in   start request, level-sampled while idle
//   q0         in   Q[0] from the datapath
//   q_1        in   Q-1 flip-flop from the datapath
//   carga_ini  out  load Q and M, clear A and Q-1
//   carga_a    out  load A from the adder/subtractor
//   resta      out  adder mode, 1 = A-M (only ever high with carga_a)
//   desplaza   out  arithmetic right shift of A:Q:Q-1
//   ocupado    out  busy: high in every state except REPOSO and FIN
//   fin        out  product valid in A:Q, held until comienzo falls
// -----------------------------------------------------------------------------
module control_booth #(
  parameter int N  = 3,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic comienzo,
  input  logic q0,
  input  logic q_1,
  output logic carga_ini,
  output logic carga_a,
  output logic resta,
  output logic desplaza,
  output logic ocupado,
  output logic fin
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CARGA    = 3'd1,
    EVALUA   = 3'd2,
    SUMA     = 3'd3,
    RESTA    = 3'd4,
    DESPLAZA = 3'd5,
    FIN      = 3'd6
  } state_t;

  localparam logic [CW-1:0] CNT_INI = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Outputs are registered: they are decoded from the next state and loaded
  // on the same edge as the state, so they always match state_q and carry no
  // combinational path from the inputs.
  logic carga_ini_q, carga_ini_d;
  logic carga_a_q,   carga_a_d;
  logic resta_q,     resta_d;
  logic desplaza_q,  desplaza_d;
  logic ocupado_q,   ocupado_d;
  logic fin_q,       fin_d;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      REPOSO: begin
        if (comienzo) state_d = CARGA;
      end
      CARGA: begin
        cnt_d   = CNT_INI;
        state_d = EVALUA;
      end
      EVALUA: begin
        // q0/q_1 are only trusted here: this state always follows a load or
        // shift edge, so the datapath bits are settled.
        unique case ({q0, q_1})
          2'b10:   state_d = RESTA;
          2'b01:   state_d = SUMA;
          default: state_d = DESPLAZA;
        endcase
      end
      SUMA: begin
        state_d = DESPLAZA;
      end
      RESTA: begin
        state_d = DESPLAZA;
      end
      DESPLAZA: begin
        // Guarded decrement: the counter can never wrap below zero.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = FIN;
        else                  state_d = EVALUA;
      end
      FIN: begin
        // A held-high comienzo keeps us here; it must drop before a new run.
        if (!comienzo) state_d = REPOSO;
      end
      default: begin
        state_d = REPOSO;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    carga_ini_d = 1'b0;
    carga_a_d   = 1'b0;
    resta_d     = 1'b0;
    desplaza_d  = 1'b0;
    ocupado_d   = 1'b0;
    fin_d       = 1'b0;
    unique case (state_d)
      CARGA: begin
        carga_ini_d = 1'b1;
        ocupado_d   = 1'b1;
      end
      EVALUA: begin
        ocupado_d   = 1'b1;
      end
      SUMA: begin
        carga_a_d   = 1'b1;
        ocupado_d   = 1'b1;
      end
      RESTA: begin
        carga_a_d   = 1'b1;
        resta_d     = 1'b1;
        ocupado_d   = 1'b1;
      end
      DESPLAZA: begin
        desplaza_d  = 1'b1;
        ocupado_d   = 1'b1;
      end
      FIN: begin
        fin_d       = 1'b1;
      end
      default: begin
        // REPOSO and any illegal encoding: everything low.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= REPOSO;
      cnt_q       <= '0;
      carga_ini_q <= 1'b0;
      carga_a_q   <= 1'b0;
      resta_q     <= 1'b0;
      desplaza_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carga_ini_q <= carga_ini_d;
      carga_a_q   <= carga_a_d;
      resta_q     <= resta_d;
      desplaza_q  <= desplaza_d;
      ocupado_q   <= ocupado_d;
      fin_q       <= fin_d;
    end
  end

  assign carga_ini = carga_ini_q;
  assign carga_a   = carga_a_q;
  assign resta     = resta_q;
  assign desplaza  = desplaza_q;
  assign ocupado   = ocupado_q;
  assign fin       = fin_q;

endmodule

// File: tb/tb_control_booth.sv
// -----------------------------------------------------------------------------
// tb_control_booth
//
// Drives control_booth together with a behavioural Booth datapath (A, Q, M,
// Q-1) that obeys the strobes. The expected strobe sequence per operation is
// derived from the Booth recoding of Q, and the final A:Q is compared with
// the signed product M*Q.
// Trace code per cycle: 0 idle/evaluate/fin, 1 carga_ini, 2 add, 3 subtract,
// 4 shift.
// -----------------------------------------------------------------------------
module tb_control_booth;

  localparam int N  = 3;
  localparam int CW = 4;
  localparam int AW = N + 1;

  logic clk = 1'b0;
  logic reset;
  logic comienzo;
  logic q0, q_1;
  logic carga_ini, carga_a, resta, desplaza, ocupado, fin;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  control_booth #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .comienzo  (comienzo),
    .q0        (q0),
    .q_1       (q_1),
    .carga_ini (carga_ini),
    .carga_a   (carga_a),
    .resta     (resta),
    .desplaza  (desplaza),
    .ocupado   (ocupado),
    .fin       (fin)
  );

  // Behavioural datapath
  logic signed [N-1:0]  op_m;
  logic        [N-1:0]  op_q;
  logic signed [AW-1:0] dp_a, dp_m;
  logic        [N-1:0]  dp_q;
  logic                 dp_q1;

  always @(posedge clk) begin
    if (carga_ini) begin
      dp_a  <= '0;
      dp_m  <= {op_m[N-1], op_m};
      dp_q  <= op_q;
      dp_q1 <= 1'b0;
    end else if (carga_a) begin
      dp_a  <= resta ? dp_a - dp_m : dp_a + dp_m;
    end else if (desplaza) begin
      {dp_a, dp_q, dp_q1} <= {dp_a[AW-1], dp_a, dp_q};
    end
  end

  assign q0  = dp_q[0];
  assign q_1 = dp_q1;

  // Per-cycle invariants
  always @(negedge clk) begin
    vecs++;
    if (reset === 1'b0) begin
      if ({carga_ini, carga_a, resta, desplaza, ocupado, fin} !== 6'b0) begin
        errs++;
        $display("FAIL inv_reset: outputs=%b required=000000",
                 {carga_ini, carga_a, resta, desplaza, ocupado, fin});
      end
    end else if (($countones({carga_ini, carga_a, desplaza}) > 1) ||
                 (resta === 1'b1 && carga_a !== 1'b1) ||
                 (ocupado === 1'b1 && fin === 1'b1) ||
                 $isunknown({carga_ini, carga_a, resta, desplaza, ocupado, fin})) begin
      errs++;
      $display("FAIL inv_cycle t=%0t: ini/a/resta/despl/ocu/fin=%b required one-hot strobes, resta->carga_a, !(ocupado&fin)",
               $time, {carga_ini, carga_a, resta, desplaza, ocupado, fin});
    end
  end

  // Trace storage
  int   exp_code [64];
  int   tr_code  [64];
  logic tr_fin   [64];
  logic tr_ocu   [64];

  function automatic int code_now();
    if (carga_ini) return 1;
    if (carga_a)   return resta ? 3 : 2;
    if (desplaza)  return 4;
    return 0;
  endfunction

  // Expected strobe sequence from Booth recoding of q (cycle 1 = load).
  task automatic build_exp(input logic [N-1:0] q, output int len, output int k);
    logic prev;
    len = 0;
    k   = 0;
    prev = 1'b0;
    len++; exp_code[len] = 1;
    for (int i = 0; i < N; i++) begin
      len++; exp_code[len] = 0;
      if (q[i] && !prev) begin
        len++; exp_code[len] = 3; k++;
      end else if (!q[i] && prev) begin
        len++; exp_code[len] = 2; k++;
      end
      len++; exp_code[len] = 4;
      prev = q[i];
    end
  endtask

  // Issue one operation and record ncyc cycles of outputs.
  task automatic run_op(input logic signed [N-1:0] m, input logic [N-1:0] q,
                        input int ncyc, input int hold_fin, input bit toggle);
    int fin_seen;
    fin_seen = 0;
    op_m = m;
    op_q = q;
    comienzo = 1'b1;
    for (int c = 1; c <= ncyc && c < 64; c++) begin
      @(posedge clk);
      #1;
      tr_code[c] = code_now();
      tr_fin[c]  = fin;
      tr_ocu[c]  = ocupado;
      if (fin) begin
        fin_seen++;
        comienzo = (fin_seen < hold_fin) ? 1'b1 : 1'b0;
      end else if (hold_fin > 0 && fin_seen == 0) begin
        comienzo = 1'b1;
      end else if (toggle && ocupado) begin
        comienzo = 1'($urandom_range(0, 1));
      end else begin
        comienzo = 1'b0;
      end
    end
    comienzo = 1'b0;
  endtask

  // One full operation checked against the Booth model.
  task automatic test_booth_op(input logic signed [N-1:0] m, input logic [N-1:0] q,
                               input bit toggle, input string name);
    int len, k;
    logic signed [N-1:0]    qs;
    logic signed [AW+N-1:0] got;
    int                     want;
    build_exp(q, len, k);
    run_op(m, q, len + 4, 0, toggle);
    for (int c = 1; c <= len; c++) begin
      vecs++;
      if (tr_code[c] !== exp_code[c] || tr_ocu[c] !== 1'b1 || tr_fin[c] !== 1'b0) begin
        errs++;
        $display("FAIL %s m=%0d q=%b cycle %0d: code=%0d ocu=%b fin=%b required code=%0d ocu=1 fin=0",
                 name, m, q, c, tr_code[c], tr_ocu[c], tr_fin[c], exp_code[c]);
      end
    end
    vecs++;
    if (tr_fin[len+1] !== 1'b1 || tr_ocu[len+1] !== 1'b0 || tr_code[len+1] !== 0) begin
      errs++;
      $display("FAIL %s_fin cycle %0d: fin=%b ocu=%b code=%0d required fin=1 ocu=0 code=0",
               name, len + 1, tr_fin[len+1], tr_ocu[len+1], tr_code[len+1]);
    end
    for (int c = len + 2; c <= len + 4; c++) begin
      vecs++;
      if (tr_fin[c] !== 1'b0 || tr_ocu[c] !== 1'b0 || tr_code[c] !== 0) begin
        errs++;
        $display("FAIL %s_idle cycle %0d: fin=%b ocu=%b code=%0d required all 0",
                 name, c, tr_fin[c], tr_ocu[c], tr_code[c]);
      end
    end
    qs   = q;
    got  = {dp_a, dp_q};
    want = int'(m) * int'(qs);
    vecs++;
    if (int'(got) !== want) begin
      errs++;
      $display("FAIL %s_product m=%0d q=%0d: A:Q=%0d required %0d", name, m, qs, int'(got), want);
    end
  endtask

  task automatic test_reset();
    bit found;
    reset = 1'b0;
    comienzo = 1'b0;
    op_m = '0;
    op_q = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({carga_ini, carga_a, resta, desplaza, ocupado, fin} !== 6'b0) begin
      errs++;
      $display("FAIL reset_state: outputs=%b required 000000",
               {carga_ini, carga_a, resta, desplaza, ocupado, fin});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Start an operation whose first pair is 10, then reset during RESTA.
    op_m = 3'sd3;
    op_q = 3'b001;
    comienzo = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      comienzo = 1'b0;
      if (carga_a === 1'b1 && resta === 1'b1) found = 1'b1;
    end
    vecs++;
    if (!found) begin
      errs++;
      $display("FAIL reset_reach_resta: resta state not seen within 20 cycles, required it");
    end
    #2;
    reset = 1'b0;
    #1;
    vecs++;
    if ({carga_ini, carga_a, resta, desplaza, ocupado, fin} !== 6'b0) begin
      errs++;
      $display("FAIL reset_async: outputs=%b required 000000 before next edge",
               {carga_ini, carga_a, resta, desplaza, ocupado, fin});
    end
    #3;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      vecs++;
      if ({carga_ini, carga_a, resta, desplaza, ocupado, fin} !== 6'b0) begin
        errs++;
        $display("FAIL reset_idle cycle %0d: outputs=%b required 000000", c,
                 {carga_ini, carga_a, resta, desplaza, ocupado, fin});
      end
    end
  endtask

  task automatic test_all_shifts();
    test_booth_op(3'sd2, 3'b000, 1'b0, "all_shifts");
    vecs++;
    if (tr_fin[7] !== 1'b0 || tr_fin[8] !== 1'b1) begin
      errs++;
      $display("FAIL all_shifts_latency: fin7=%b fin8=%b required 0,1", tr_fin[7], tr_fin[8]);
    end
  endtask

  task automatic test_mixed();
    test_booth_op(3'sd3, 3'b010, 1'b0, "mixed");
    vecs++;
    if (tr_fin[9] !== 1'b0 || tr_fin[10] !== 1'b1 || tr_code[5] !== 3 || tr_code[8] !== 2) begin
      errs++;
      $display("FAIL mixed_shape: fin9=%b fin10=%b c5=%0d c8=%0d required 0,1,3,2",
               tr_fin[9], tr_fin[10], tr_code[5], tr_code[8]);
    end
  endtask

  task automatic test_worst();
    test_booth_op(3'sd3, 3'b101, 1'b0, "worst");
    vecs++;
    if (tr_fin[10] !== 1'b0 || tr_fin[11] !== 1'b1) begin
      errs++;
      $display("FAIL worst_latency: fin10=%b fin11=%b required 0,1", tr_fin[10], tr_fin[11]);
    end
  endtask

  task automatic test_handshake();
    int len, k, ones;
    build_exp(3'b000, len, k);
    run_op(-3'sd1, 3'b000, len + 8, 5, 1'b0);
    for (int c = len + 1; c <= len + 5; c++) begin
      vecs++;
      if (tr_fin[c] !== 1'b1 || tr_code[c] !== 0) begin
        errs++;
        $display("FAIL handshake_hold cycle %0d: fin=%b code=%0d required fin=1 code=0",
                 c, tr_fin[c], tr_code[c]);
      end
    end
    vecs++;
    if (tr_fin[len+6] !== 1'b0 || tr_ocu[len+6] !== 1'b0 || tr_code[len+6] !== 0) begin
      errs++;
      $display("FAIL handshake_drop: fin=%b ocu=%b code=%0d required all 0",
               tr_fin[len+6], tr_ocu[len+6], tr_code[len+6]);
    end
    ones = 0;
    for (int c = 1; c <= len + 8; c++) if (tr_code[c] == 1) ones++;
    vecs++;
    if (ones !== 1) begin
      errs++;
      $display("FAIL handshake_retrigger: carga_ini pulses=%0d required 1", ones);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 4; i++)
      test_booth_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, "toggle");
  endtask

  task automatic test_random();
    test_booth_op(-3'sd4, 3'b100, 1'b0, "rand_edge");
    test_booth_op(-3'sd4, 3'b111, 1'b0, "rand_edge");
    for (int i = 0; i < 16; i++)
      test_booth_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_all_shifts();
    test_mixed();
    test_worst();
    test_handshake();
    test_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
